// File: rtl/alu_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_pipe
// Purpose  : Two-stage valid/ready pipelined 8-bit shift unit (SRL, SLL, SRA,
//            ROR) for the KGP ALU. S1 registers the request, the shifters sit
//            between S1 and S2, and S2 registers the result, flags and tag.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            in_valid/in_ready         - request handshake
//            in_a, in_shamt, in_op     - operand, shift amount 0..7, operation
//                                        (00 SRL, 01 SLL, 10 SRA, 11 ROR)
//            in_tag                    - opaque tag returned with the result
//            out_valid/out_ready       - result handshake
//            out_result, out_carry     - shifted value, last bit shifted out
//            out_zero, out_neg         - result == 0, result[7]
//            out_tag                   - tag of the presented result
// Revision : 1.0 - initial release
// ============================================================================
module alu_shift_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [2:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] c_OP_SRL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROR = 2'b11;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [7:0]       r_s1_a;
    logic [2:0]       r_s1_shamt;
    logic [1:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [7:0]       r_s2_result;
    logic             r_s2_carry;
    logic             r_s2_zero;
    logic             r_s2_neg;
    logic [TAG_W-1:0] r_s2_tag;

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;

    // Datapath
    logic [7:0]        w_srl;
    logic [7:0]        w_sll;
    logic signed [7:0] w_sra;
    logic [15:0]       w_rot;
    logic [2:0]        w_srl_idx;
    logic [2:0]        w_sll_idx;
    logic [7:0]        w_res;
    logic              w_carry;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_srl = r_s1_a >> r_s1_shamt;
    assign w_sll = r_s1_a << r_s1_shamt;
    assign w_sra = $signed(r_s1_a) >>> r_s1_shamt;
    // Right rotation: shift the doubled operand, the low byte is the rotation.
    assign w_rot = {r_s1_a, r_s1_a} >> r_s1_shamt;

    // Bit index of the last bit pushed out. For SLL 8-s equals -s modulo 8;
    // both indices are only meaningful for s != 0, which is masked below.
    assign w_srl_idx = r_s1_shamt - 3'd1;
    assign w_sll_idx = 3'd0 - r_s1_shamt;

    always_comb begin
        w_res   = r_s1_a;
        w_carry = 1'b0;
        case (r_s1_op)
            c_OP_SRL: begin
                w_res   = w_srl;
                w_carry = r_s1_a[w_srl_idx];
            end
            c_OP_SLL: begin
                w_res   = w_sll;
                w_carry = r_s1_a[w_sll_idx];
            end
            c_OP_SRA: begin
                w_res   = w_sra;
                w_carry = r_s1_a[w_srl_idx];
            end
            c_OP_ROR: begin
                w_res   = w_rot[7:0];
                w_carry = w_rot[7];
            end
            default: begin
                w_res   = r_s1_a;
                w_carry = 1'b0;
            end
        endcase
        if (r_s1_shamt == 3'd0) begin
            w_carry = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 8'h00;
            r_s1_shamt <= 3'd0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a     <= in_a;
                r_s1_shamt <= in_shamt;
                r_s1_op    <= in_op;
                r_s1_tag   <= in_tag;
            end
        end
    end

    // S2 data only updates when a real transaction moves in, so the outputs
    // keep their last value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= 8'h00;
            r_s2_carry  <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_neg    <= 1'b0;
            r_s2_tag    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_res;
                r_s2_carry  <= w_carry;
                r_s2_zero   <= (w_res == 8'h00);
                r_s2_neg    <= w_res[7];
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_carry  = r_s2_carry;
    assign out_zero   = r_s2_zero;
    assign out_neg    = r_s2_neg;
    assign out_tag    = r_s2_tag;

endmodule
`default_nettype wire

// File: doc/alu_shift_pipe.md
# alu_shift_pipe

Two-stage, valid/ready-pipelined shift unit for the 8-bit KGP ALU. It registers shift requests from the ALU issue logic and drives them through the combinational shifters: the existing `shiftrightlogical` for SRL, plus sibling SLL, SRA and ROR datapaths. It then registers the result, a tag and status flags for the writeback/flag logic downstream. It sustains one request per cycle with full backpressure and never drops or duplicates a transaction.

## Interface
Parameters:
- `TAG_W`, default 4: width of the opaque request tag carried alongside each request.

Ports:
- `clk`, in, 1: the only clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: a request is presented.
- `in_ready`, out, 1: the stage can accept the request this cycle.
- `in_a`, in, 8: operand.
- `in_shamt`, in, 3: shift amount, 0–7.
- `in_op`, in, 2: operation. 00 = SRL, 01 = SLL, 10 = SRA, 11 = ROR.
- `in_tag`, in, `TAG_W`: tag, returned unchanged with the result.
- `out_valid`, out, 1: a result is presented.
- `out_ready`, in, 1: the consumer accepts the result this cycle.
- `out_result`, out, 8: shifted value.
- `out_carry`, out, 1: last bit shifted or rotated out.
- `out_zero`, out, 1: `out_result == 0`.
- `out_neg`, out, 1: `out_result[7]`.
- `out_tag`, out, `TAG_W`: tag of this result.

## Operation
- Stage 1 (S1) holds the registers `s1_valid`, `a`, `shamt`, `op` and `tag`.
- Stage 2 (S2) holds `s2_valid`, `result`, the three flags and `tag`.
- The shift datapath is combinational between S1 and S2.
- Advance rules:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv`. This is combinational, so no bubble is inserted.
- Accept: when `in_valid & in_ready`, S1 loads the request and `s1_valid` is set to 1.
- Otherwise, when `s1_adv` is high, `s1_valid` is cleared to 0.
- On `s2_adv`, S2 loads the datapath output and `s2_valid <= s1_valid`.
- While `s2_adv` is low, S2 holds and all `out_*` signals stay stable.
- Result and carry rules, with s = shamt:
  - SRL: `a >> s`, zero-filled. carry = `a[s-1]`.
  - SLL: `a << s`, zero-filled. carry = `a[8-s]`.
  - SRA: `a >> s`, filled with `a[7]`. carry = `a[s-1]`.
  - ROR: `a` rotated right by `s`. carry = `result[7]`.
- When s = 0 for any op: result = `a` and carry = 0.
- Flags are computed from the final 8-bit result only. There is no overflow flag.
- `out_result`, the flags and `out_tag` are meaningful only while `out_valid` = 1. They are register outputs with no combinational path from the inputs.
- Simultaneous events:
  - Accept at S1 and drain at S2 in the same cycle is legal. S1's old contents move to S2, and the new request enters S1.
  - A full pipe with `out_ready` high keeps `in_ready` high, so throughput is 1 per cycle.
  - A full pipe with `out_ready` low drops `in_ready` low in that same cycle.

## Timing
- Reset values: `s1_valid` = 0 and `s2_valid` = 0, so `out_valid` = 0. Also `out_result` = 8'h00, `out_carry` = 0, `out_zero` = 0, `out_neg` = 0, `out_tag` = 0.
- `in_ready` = 1 in the first cycle after reset deasserts.
- Reset has priority over every handshake. Any reset mid-operation discards both stages, and no partial result appears afterwards.
- Latency: a request accepted at edge k gives `out_valid` = 1 after edge k+1. That is 2 edges when `out_ready` is held high.
- Throughput: 1 result per cycle under continuous `in_valid` and `out_ready`.
- Capacity: 2 requests. With `out_ready` held low, at most 2 requests are accepted, then `in_ready` = 0.
- Order is strict FIFO. Tags emerge in acceptance order.
- Consumer rule: once `out_valid` is asserted, it and the `out_*` data hold until the cycle in which `out_ready` = 1.
- Producer rule: `in_*` may change freely while `in_ready` = 0. Such cycles are not sampled.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 2 cycles, then release.
  - Required: `out_valid` = 0 and all `out_*` = 0 during reset, and `in_ready` = 1 on the first cycle after release.
- Single SRL and SRA:
  - Stimulus: `a` = 8'hB4, `shamt` = 3, `op` = SRL, tag 5.
  - Required: two edges later, result = 8'h16, carry = 1, zero = 0, neg = 0, tag = 5.
  - Stimulus: the same operands with `op` = SRA.
  - Required: result = 8'hF6, carry = 1, neg = 1.
- SLL, ROR, zero flag and s = 0:
  - 8'h81 SLL 1 gives 8'h02, carry = 1.
  - 8'h01 ROR 1 gives 8'h80, carry = 1, neg = 1.
  - 8'h07 SRL 3 gives 8'h00, carry = 1, zero = 1.
  - 8'h5A with any op and `shamt` = 0 gives 8'h5A, carry = 0.
- Backpressure:
  - Stimulus: `out_ready` = 0, and tags 1, 2, 3 offered back-to-back.
  - Required: tags 1 and 2 are accepted, `in_ready` = 0 while tag 3 is held, and `out_*` stay stable.
  - Stimulus: raise `out_ready`.
  - Required: tags 1, 2, 3 emerge in order on consecutive cycles, with no loss or duplication.
- Streaming:
  - Stimulus: 256 random requests, with `out_ready` held at 1 and then toggled randomly.
  - Required: 1 result per cycle when unthrottled, and every result matches the reference model in order.
- Reset mid-flight:
  - Stimulus: with both stages valid, pulse `rst` for 1 cycle.
  - Required: `out_valid` = 0 from the next cycle and no stale result ever appears. A new request issued afterwards completes with 2-edge latency.
